// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
// Module   : alu_mc
// Brief    : Multi-cycle ALU. Single-cycle ops (add/sub/logic/shift) finish
//            on the acceptance edge; MUL runs a DATA_WIDTH-step shift-add
//            sequence. Result and flags are held until the consumer takes them.
// Revision : 1.0 - initial release
// ============================================================================
module alu_mc #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [2:0]            alu_op,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic [3:0]            flags
);

  // Shift amount width; also wide enough to count 0..DATA_WIDTH-1 MUL steps.
  localparam int SHW = $clog2(DATA_WIDTH);

  localparam logic [2:0] c_op_add  = 3'b000;
  localparam logic [2:0] c_op_xor  = 3'b001;
  localparam logic [2:0] c_op_pass = 3'b010;
  localparam logic [2:0] c_op_sub  = 3'b011;
  localparam logic [2:0] c_op_and  = 3'b100;
  localparam logic [2:0] c_op_or   = 3'b101;
  localparam logic [2:0] c_op_sll  = 3'b110;
  localparam logic [2:0] c_op_mul  = 3'b111;

  localparam logic [SHW-1:0] c_last_step = SHW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [DATA_WIDTH-1:0]     result_q, result_d;
  logic [3:0]                flags_q, flags_d;
  logic [SHW-1:0]            cnt_q, cnt_d;
  logic [2*DATA_WIDTH-1:0]   acc_q, acc_d;
  logic [2*DATA_WIDTH-1:0]   mcand_q, mcand_d;
  logic [DATA_WIDTH-1:0]     mplier_q, mplier_d;

  logic [DATA_WIDTH:0]       w_sum;
  logic [DATA_WIDTH-1:0]     w_alu_res;
  logic                      w_alu_carry;
  logic                      w_alu_ovf;
  logic [2*DATA_WIDTH-1:0]   w_acc_next;
  logic [DATA_WIDTH-1:0]     w_mul_lo;
  logic [DATA_WIDTH-1:0]     w_mul_hi;

  // Single-cycle ALU evaluated straight from the request inputs; only used
  // on the acceptance edge, so later input changes cannot reach the result.
  always_comb begin
    w_sum       = '0;
    w_alu_res   = '0;
    w_alu_carry = 1'b0;
    w_alu_ovf   = 1'b0;
    case (alu_op)
      c_op_add: begin
        w_sum       = {1'b0, a} + {1'b0, b};
        w_alu_res   = w_sum[DATA_WIDTH-1:0];
        w_alu_carry = w_sum[DATA_WIDTH];
        w_alu_ovf   = (a[DATA_WIDTH-1] == b[DATA_WIDTH-1]) &&
                      (w_alu_res[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
      end
      c_op_sub: begin
        // The extra top bit of the widened difference is the unsigned borrow.
        w_sum       = {1'b0, a} - {1'b0, b};
        w_alu_res   = w_sum[DATA_WIDTH-1:0];
        w_alu_carry = w_sum[DATA_WIDTH];
        w_alu_ovf   = (a[DATA_WIDTH-1] != b[DATA_WIDTH-1]) &&
                      (w_alu_res[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
      end
      c_op_xor:  w_alu_res = a ^ b;
      c_op_pass: w_alu_res = b;
      c_op_and:  w_alu_res = a & b;
      c_op_or:   w_alu_res = a | b;
      c_op_sll:  w_alu_res = a << b[SHW-1:0];
      default:   w_alu_res = '0;
    endcase
  end

  // One shift-add multiply step: add the shifted multiplicand when the
  // current multiplier LSB is set.
  always_comb begin
    w_acc_next = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    w_mul_lo   = w_acc_next[DATA_WIDTH-1:0];
    w_mul_hi   = w_acc_next[2*DATA_WIDTH-1:DATA_WIDTH];
  end

  // Next-state and datapath update; every target defaults to holding.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flags_d  = flags_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (alu_op == c_op_mul) begin
            state_d  = S_MUL;
            cnt_d    = '0;
            acc_d    = '0;
            mcand_d  = {{DATA_WIDTH{1'b0}}, a};
            mplier_d = b;
          end else begin
            state_d  = S_DONE;
            result_d = w_alu_res;
            flags_d  = {w_alu_res[DATA_WIDTH-1], (w_alu_res == '0),
                        w_alu_carry, w_alu_ovf};
          end
        end
      end
      S_MUL: begin
        acc_d    = w_acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + SHW'(1);
        if (cnt_q == c_last_step) begin
          state_d  = S_DONE;
          result_d = w_mul_lo;
          flags_d  = {w_mul_lo[DATA_WIDTH-1], (w_mul_lo == '0),
                      (w_mul_hi != '0), 1'b0};
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      flags_q  <= 4'b0100;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign flags     = flags_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_mc
// Brief    : Self-checking bench for alu_mc (DATA_WIDTH=16). A transaction-
//            level model predicts handshake and outputs every cycle; directed
//            vectors carry hand-computed results, flags and latencies.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_mc;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [2:0]    alu_op;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic [3:0]    flags;

  int total = 0;
  int bad   = 0;
  bit checking = 1'b0;

  alu_mc #(.DATA_WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .alu_op    (alu_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (plain arithmetic) ----------------
  function automatic logic [W-1:0] exp_res(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [31:0] p;
    p = 32'(x) * 32'(y);
    case (op)
      3'b000:  return x + y;
      3'b001:  return x ^ y;
      3'b010:  return y;
      3'b011:  return x - y;
      3'b100:  return x & y;
      3'b101:  return x | y;
      3'b110:  return x << y[3:0];
      default: return p[15:0];
    endcase
  endfunction

  function automatic logic [3:0] exp_flags(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] r;
    logic c, v;
    int s;
    r = exp_res(op, x, y);
    c = 1'b0;
    v = 1'b0;
    case (op)
      3'b000: begin
        c = (32'(x) + 32'(y)) > 32'h0000_FFFF;
        s = int'($signed(x)) + int'($signed(y));
        v = (s > 32767) || (s < -32768);
      end
      3'b011: begin
        c = (x < y);
        s = int'($signed(x)) - int'($signed(y));
        v = (s > 32767) || (s < -32768);
      end
      3'b111: c = (32'(x) * 32'(y)) > 32'h0000_FFFF;
      default: ;
    endcase
    return {r[W-1], (r == 0), c, v};
  endfunction

  // Transaction view: an accepted request produces its result after a fixed
  // latency (1, or 17 for MUL), held until the consumer takes it.
  logic          m_valid, m_pending;
  int            m_wait;
  logic [W-1:0]  m_res, p_res;
  logic [3:0]    m_flags, p_flags;

  always @(posedge clk) begin
    if (rst) begin
      m_valid   <= 1'b0;
      m_pending <= 1'b0;
      m_wait    <= 0;
      m_res     <= '0;
      m_flags   <= 4'b0100;
    end else if (m_valid) begin
      if (out_ready) m_valid <= 1'b0;
    end else if (m_pending) begin
      m_wait <= m_wait - 1;
      if (m_wait == 1) begin
        m_pending <= 1'b0;
        m_valid   <= 1'b1;
        m_res     <= p_res;
        m_flags   <= p_flags;
      end
    end else if (in_valid) begin
      if (alu_op == 3'b111) begin
        m_pending <= 1'b1;
        m_wait    <= 16;
        p_res     <= exp_res(alu_op, a, b);
        p_flags   <= exp_flags(alu_op, a, b);
      end else begin
        m_valid <= 1'b1;
        m_res   <= exp_res(alu_op, a, b);
        m_flags <= exp_flags(alu_op, a, b);
      end
    end
  end

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (checking) begin
      chk("cyc_in_ready", 32'(in_ready), 32'(!(m_valid || m_pending)));
      chk("cyc_out_valid", 32'(out_valid), 32'(m_valid));
      chk("cyc_result", 32'(result), 32'(m_res));
      chk("cyc_flags", 32'(flags), 32'(m_flags));
    end
  end

  // Issue one request and check result, flags and latency against literals.
  task automatic do_op(input logic [2:0] op, input logic [W-1:0] va, input logic [W-1:0] vb,
                       input logic [W-1:0] er, input logic [3:0] ef, input int el,
                       input bit hold_rdy, input bit release_out);
    int lat;
    bit saw_ready;
    @(posedge clk); #2;
    chk("idle_before_issue", 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    alu_op    = op;
    a         = va;
    b         = vb;
    out_ready = hold_rdy;
    @(posedge clk); #2;
    in_valid = 1'b0;
    a        = 16'($urandom);
    b        = 16'($urandom);
    alu_op   = 3'($urandom);
    lat = 1;
    saw_ready = 1'b0;
    while (!out_valid && lat < 40) begin
      if (in_ready) saw_ready = 1'b1;
      @(posedge clk); #2;
      lat++;
    end
    chk("latency", 32'(lat), 32'(el));
    chk("lit_result", 32'(result), 32'(er));
    chk("lit_flags", 32'(flags), 32'(ef));
    if (el > 1) chk("busy_not_ready", 32'(saw_ready), 32'd0);
    if (hold_rdy) begin
      @(posedge clk); #2;
      chk("done_one_cycle", 32'(out_valid), 32'd0);
      out_ready = 1'b0;
    end else if (release_out) begin
      out_ready = 1'b1;
      @(posedge clk); #2;
      out_ready = 1'b0;
      chk("release_idle", 32'(in_ready), 32'd1);
      chk("release_no_valid", 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; alu_op = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_flags", 32'(flags), 32'b0100);
    checking = 1'b1;

    do_op(3'b000, 16'h7FFF, 16'h0001, 16'h8000, 4'b1001, 1,  0, 1);
    do_op(3'b011, 16'h0003, 16'h0005, 16'hFFFE, 4'b1010, 1,  0, 1);
    do_op(3'b011, 16'h1234, 16'h1234, 16'h0000, 4'b0100, 1,  0, 1);
    do_op(3'b111, 16'h0100, 16'h0100, 16'h0000, 4'b0110, 17, 0, 1);
    do_op(3'b110, 16'h0001, 16'h000F, 16'h8000, 4'b1000, 1,  0, 1);
    do_op(3'b110, 16'h0001, 16'h0010, 16'h0001, 4'b0000, 1,  0, 1);
    do_op(3'b001, 16'h00FF, 16'h0F0F, 16'h0FF0, 4'b0000, 1,  0, 1);
    do_op(3'b010, 16'h1234, 16'h8001, 16'h8001, 4'b1000, 1,  0, 1);
    do_op(3'b100, 16'hF0F0, 16'hFF00, 16'hF000, 4'b1000, 1,  0, 1);
    do_op(3'b101, 16'h0001, 16'h0100, 16'h0101, 4'b0000, 1,  0, 1);
    do_op(3'b000, 16'hFFFF, 16'h0001, 16'h0000, 4'b0110, 1,  0, 1);
    do_op(3'b011, 16'h8000, 16'h0001, 16'h7FFF, 4'b0001, 1,  0, 1);
    do_op(3'b111, 16'hFFFF, 16'hFFFF, 16'h0001, 4'b0010, 17, 0, 1);
    do_op(3'b111, 16'h0003, 16'h0005, 16'h000F, 4'b0000, 17, 1, 0);
    do_op(3'b000, 16'h0005, 16'h0006, 16'h000B, 4'b0000, 1,  1, 0);

    // Hold in DONE while inputs churn; nothing may move or be accepted.
    do_op(3'b000, 16'h0010, 16'h0020, 16'h0030, 4'b0000, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #2;
      in_valid = 1'($urandom);
      a        = 16'($urandom);
      b        = 16'($urandom);
      alu_op   = 3'($urandom);
      chk("hold_result", 32'(result), 32'h0030);
      chk("hold_flags", 32'(flags), 32'b0000);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_not_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #2;
    out_ready = 1'b0;
    chk("hold_exit_ready", 32'(in_ready), 32'd1);
    chk("hold_exit_valid", 32'(out_valid), 32'd0);

    // Reset in the middle of a multiply.
    @(posedge clk); #2;
    in_valid = 1'b1; alu_op = 3'b111; a = 16'd3; b = 16'd5;
    @(posedge clk); #2;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    chk("mul_busy_at_abort", 32'(in_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_flags", 32'(flags), 32'b0100);
    repeat (20) begin
      @(posedge clk); #2;
      chk("abort_no_pulse", 32'(out_valid), 32'd0);
    end
    do_op(3'b000, 16'h0002, 16'h0002, 16'h0004, 4'b0000, 1, 0, 1);

    repeat (2) @(posedge clk);
    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, giving the operand/result width; legal values are 4 to 64, powers of two.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port in_valid  input  1  the request holds a valid operation.
REQ-005 The block SHALL have port in_ready  output  1  the block can accept a request this cycle.
REQ-006 The block SHALL have port a  input  DATA_WIDTH  operand A.
REQ-007 The block SHALL have port b  input  DATA_WIDTH  operand B or shift amount.
REQ-008 The block SHALL have port alu_op  input  3  operation select, per REQ-014.
REQ-009 The block SHALL have port out_valid  output  1  result and flags are valid.
REQ-010 The block SHALL have port out_ready  input  1  the consumer takes the result.
REQ-011 The block SHALL have port result  output  DATA_WIDTH  registered result.
REQ-012 The block SHALL have port flags  output  4  registered {neg, zero, carry, ovf} (bit 3 down to bit 0).

Function
REQ-013 The block SHALL run a state machine with states IDLE, MUL and DONE; in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-014 The alu_op encoding SHALL be: 000 ADD a+b; 001 XOR; 010 PASS b; 011 SUB a-b; 100 AND; 101 OR; 110 SLL, a shifted left by b[log2(DATA_WIDTH)-1:0] with zero fill; 111 MUL, the low DATA_WIDTH bits of unsigned a*b.
REQ-015 Acceptance SHALL happen on an edge where state is IDLE and in_valid=1; a, b and alu_op SHALL be captured only at acceptance, and later input changes SHALL not affect the result.
REQ-016 For op codes 000-110, the acceptance edge SHALL register result and flags and move to DONE, so out_valid is 1 in the next cycle (latency 1).
REQ-017 For MUL, the acceptance edge SHALL move to MUL and clear the step counter and accumulator.
REQ-018 In the MUL state, each edge SHALL perform one shift-add step; after exactly DATA_WIDTH steps the block SHALL move to DONE (latency DATA_WIDTH+1).
REQ-019 In DONE, result, flags and out_valid SHALL hold stable until an edge with out_ready=1, which SHALL move the block to IDLE.
REQ-020 The minimum issue interval SHALL be 2 cycles, because acceptance and output are never in the same cycle.
REQ-021 The zero flag SHALL be (result==0) and the neg flag SHALL be result[DATA_WIDTH-1], for all ops.
REQ-022 The carry flag SHALL be:
- ADD: the carry out of bit DATA_WIDTH-1;
- SUB: the unsigned borrow (a<b);
- MUL: 1 when the high product half is non-zero;
- all other ops: 0.
REQ-023 The ovf flag SHALL be the two's-complement signed overflow for ADD and SUB, and 0 for all other ops.
REQ-024 ADD and SUB SHALL wrap modulo 2^DATA_WIDTH.
REQ-025 An SLL amount of 0 SHALL return a unchanged.
REQ-026 in_valid seen outside IDLE SHALL be ignored and not queued.
REQ-027 When out_ready is held at 1 before DONE is reached, DONE SHALL last exactly one cycle.

Reset
REQ-028 While rst=1 at an edge, the block SHALL set state=IDLE, result=0, flags=4'b0100 (zero set), out_valid=0, in_ready=1 from the next cycle, and clear the step counter; rst SHALL take priority over all other inputs.
REQ-029 A reset during MUL or DONE SHALL abort the operation with no out_valid pulse, and the aborted result SHALL never appear.

Verification
REQ-030 Bench SHALL drive ADD, a=16'h7FFF, b=16'h0001 -> result=16'h8000, flags=1001 (neg, ovf), out_valid one cycle after acceptance.
REQ-031 Bench SHALL drive SUB, a=16'h0003, b=16'h0005 -> result=16'hFFFE, flags=1010 (neg, carry/borrow); then SUB a=b=16'h1234 -> result=0, flags=0100.
REQ-032 Bench SHALL drive MUL, a=16'h0100, b=16'h0100 -> result=16'h0000, flags=0110 (zero, carry), out_valid exactly 17 cycles after acceptance, in_ready=0 throughout.
REQ-033 Bench SHALL drive SLL, a=16'h0001, b=16'h000F -> result=16'h8000; then SLL b=16'h0010 (amount 0) -> result=16'h0001.
REQ-034 Bench SHALL hold out_ready=0 for 5 cycles in DONE while toggling a, b and in_valid -> result, flags and out_valid are stable and no new request is accepted; out_ready=1 -> IDLE next cycle.
REQ-035 Bench SHALL assert rst at MUL step 8 of a=3, b=5 -> next cycle in_ready=1, out_valid=0, result=0; a following ADD 2+2 returns 4.
